// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: entry type encodings and the entry record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reorder_buffer_pkg;

    typedef enum logic [1:0] {
        ROB_TYPE_REG    = 2'd0,
        ROB_TYPE_STORE  = 2'd1,
        ROB_TYPE_BRANCH = 2'd2
    } rob_type_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        rob_type_e   rtype;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        pred_taken;
        logic        taken;
        logic [31:0] alt_pc;
    } rob_entry_t;

    localparam rob_entry_t ENTRY_RST = '0;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates indices 1..2^ROB_WIDTH-1, captures CDB results, retires in order.
// Latency: CDB result at edge E makes the entry ready after E; a ready head commits at E+1 (registered pulses).
// Backpressure: rob_full (registered count) blocks issue; rdy_in low freezes all state and outputs.
//
// Ports:
//   clk_in, rst_in (sync active-low), rdy_in (global stall)
//   issue_*        : allocate one entry at rob_next_idx (tail)
//   alu/lsb_cdb_*  : result broadcasts, write val/ready (ALU also writes taken)
//   rs1/rs2_query  : combinational readiness/value lookup with CDB bypass; index 0 = no dependency
//   rob_to_rf_*    : register commit pulse (REG and BRANCH)
//   rob_to_lsb_*   : store release pulse
//   clr_out/clr_pc : pipeline flush on branch mispredict
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,

    input  logic                 issue_rdy,
    input  logic [1:0]           issue_type,
    input  logic [4:0]           issue_rd_id,
    input  logic                 issue_pred_taken,
    input  logic [31:0]          issue_alt_pc,
    output logic                 rob_full,
    output logic [ROB_WIDTH-1:0] rob_next_idx,

    input  logic                 alu_cdb_valid,
    input  logic [ROB_WIDTH-1:0] alu_cdb_rob_idx,
    input  logic [31:0]          alu_cdb_val,
    input  logic                 alu_cdb_taken,
    input  logic                 lsb_cdb_valid,
    input  logic [ROB_WIDTH-1:0] lsb_cdb_rob_idx,
    input  logic [31:0]          lsb_cdb_val,

    input  logic [ROB_WIDTH-1:0] rs1_query_idx,
    input  logic [ROB_WIDTH-1:0] rs2_query_idx,
    output logic                 rs1_ready,
    output logic                 rs2_ready,
    output logic [31:0]          rs1_val,
    output logic [31:0]          rs2_val,

    output logic                 rob_to_rf_commit,
    output logic [4:0]           rob_to_rf_reg_id,
    output logic [31:0]          rob_to_rf_reg_val,
    output logic [ROB_WIDTH-1:0] rob_to_rf_rob_idx,
    output logic                 rob_to_lsb_store_commit,
    output logic [ROB_WIDTH-1:0] rob_to_lsb_store_idx,
    output logic                 clr_out,
    output logic [31:0]          clr_pc
);

    localparam int                   DEPTH   = 2 ** ROB_WIDTH;
    localparam logic [ROB_WIDTH-1:0] IDX_ONE = {{(ROB_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ROB_WIDTH-1:0] CAP_CNT = '1;

    // Index 0 means "no dependency", so the pointers skip it on wrap.
    function automatic logic [ROB_WIDTH-1:0] idx_inc(input logic [ROB_WIDTH-1:0] idx);
        return (idx == '1) ? IDX_ONE : idx + IDX_ONE;
    endfunction

    rob_entry_t           ent_q [DEPTH];
    logic [ROB_WIDTH-1:0] head_q, tail_q, count_q, count_d;
    logic                 full_q;
    logic                 rf_commit_q, st_commit_q, clr_q;
    logic [4:0]           rf_reg_id_q;
    logic [31:0]          rf_reg_val_q, clr_pc_q;
    logic [ROB_WIDTH-1:0] rf_rob_idx_q, st_idx_q;

    rob_entry_t head_ent;
    logic       issue_fire, commit_fire, mispredict;

    assign head_ent    = ent_q[head_q];
    // The clear cycle squashes issue and CDB; the flush already emptied every entry.
    assign commit_fire = !clr_q && head_ent.busy && head_ent.ready;
    assign mispredict  = commit_fire && (head_ent.rtype == ROB_TYPE_BRANCH)
                         && (head_ent.taken != head_ent.pred_taken);
    // Full test uses the registered count, so a same-cycle commit does not free a slot early.
    assign issue_fire  = issue_rdy && (count_q != CAP_CNT) && !clr_q;

    always_comb begin
        case ({issue_fire, commit_fire})
            2'b10:   count_d = count_q + IDX_ONE;
            2'b01:   count_d = count_q - IDX_ONE;
            default: count_d = count_q;
        endcase
    end

    // Operand lookup: same-cycle CDB bypass first (ALU before LSB), then stored entry.
    always_comb begin
        rs1_ready = 1'b0;
        rs1_val   = '0;
        if (rs1_query_idx == '0) begin
            rs1_ready = 1'b1;
        end else if (alu_cdb_valid && (alu_cdb_rob_idx == rs1_query_idx)) begin
            rs1_ready = 1'b1;
            rs1_val   = alu_cdb_val;
        end else if (lsb_cdb_valid && (lsb_cdb_rob_idx == rs1_query_idx)) begin
            rs1_ready = 1'b1;
            rs1_val   = lsb_cdb_val;
        end else begin
            rs1_ready = ent_q[rs1_query_idx].ready;
            rs1_val   = ent_q[rs1_query_idx].val;
        end
    end

    always_comb begin
        rs2_ready = 1'b0;
        rs2_val   = '0;
        if (rs2_query_idx == '0) begin
            rs2_ready = 1'b1;
        end else if (alu_cdb_valid && (alu_cdb_rob_idx == rs2_query_idx)) begin
            rs2_ready = 1'b1;
            rs2_val   = alu_cdb_val;
        end else if (lsb_cdb_valid && (lsb_cdb_rob_idx == rs2_query_idx)) begin
            rs2_ready = 1'b1;
            rs2_val   = lsb_cdb_val;
        end else begin
            rs2_ready = ent_q[rs2_query_idx].ready;
            rs2_val   = ent_q[rs2_query_idx].val;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ENTRY_RST;
            end
            head_q       <= IDX_ONE;
            tail_q       <= IDX_ONE;
            count_q      <= '0;
            full_q       <= 1'b0;
            rf_commit_q  <= 1'b0;
            rf_reg_id_q  <= '0;
            rf_reg_val_q <= '0;
            rf_rob_idx_q <= '0;
            st_commit_q  <= 1'b0;
            st_idx_q     <= '0;
            clr_q        <= 1'b0;
            clr_pc_q     <= '0;
        end else if (rdy_in) begin
            rf_commit_q <= 1'b0;
            st_commit_q <= 1'b0;
            clr_q       <= 1'b0;

            if (issue_fire) begin
                ent_q[tail_q] <= '{busy:       1'b1,
                                   ready:      1'b0,
                                   rtype:      rob_type_e'(issue_type),
                                   rd:         issue_rd_id,
                                   val:        32'd0,
                                   pred_taken: issue_pred_taken,
                                   taken:      1'b0,
                                   alt_pc:     issue_alt_pc};
            end

            if (!clr_q && alu_cdb_valid && ent_q[alu_cdb_rob_idx].busy) begin
                ent_q[alu_cdb_rob_idx].ready <= 1'b1;
                ent_q[alu_cdb_rob_idx].val   <= alu_cdb_val;
                ent_q[alu_cdb_rob_idx].taken <= alu_cdb_taken;
            end
            if (!clr_q && lsb_cdb_valid && ent_q[lsb_cdb_rob_idx].busy) begin
                ent_q[lsb_cdb_rob_idx].ready <= 1'b1;
                ent_q[lsb_cdb_rob_idx].val   <= lsb_cdb_val;
            end

            if (commit_fire) begin
                ent_q[head_q].busy <= 1'b0;
                if (head_ent.rtype == ROB_TYPE_STORE) begin
                    st_commit_q <= 1'b1;
                    st_idx_q    <= head_q;
                end else begin
                    rf_commit_q  <= 1'b1;
                    rf_reg_id_q  <= head_ent.rd;
                    rf_reg_val_q <= head_ent.val;
                    rf_rob_idx_q <= head_q;
                end
            end

            head_q  <= commit_fire ? idx_inc(head_q) : head_q;
            tail_q  <= issue_fire ? idx_inc(tail_q) : tail_q;
            count_q <= count_d;
            full_q  <= (count_d == CAP_CNT);

            // Flush overrides the issue and pointer updates above.
            if (mispredict) begin
                for (int i = 0; i < DEPTH; i++) begin
                    ent_q[i].busy <= 1'b0;
                end
                clr_q    <= 1'b1;
                clr_pc_q <= head_ent.alt_pc;
                head_q   <= IDX_ONE;
                tail_q   <= IDX_ONE;
                count_q  <= '0;
                full_q   <= 1'b0;
            end
        end
    end

    assign rob_full                = full_q;
    assign rob_next_idx            = tail_q;
    assign rob_to_rf_commit        = rf_commit_q;
    assign rob_to_rf_reg_id        = rf_reg_id_q;
    assign rob_to_rf_reg_val       = rf_reg_val_q;
    assign rob_to_rf_rob_idx       = rf_rob_idx_q;
    assign rob_to_lsb_store_commit = st_commit_q;
    assign rob_to_lsb_store_idx    = st_idx_q;
    assign clr_out                 = clr_q;
    assign clr_pc                  = clr_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer (ROB_WIDTH=3, 7 entries).
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after posedge or at negedge.
// Backpressure: commits checked against an in-order scoreboard of expected retirements.
module tb_reorder_buffer;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_in = 1'b0, rdy_in = 1'b1;
    logic         issue_rdy = 1'b0, issue_pred_taken = 1'b0;
    logic [1:0]   issue_type = 2'd0;
    logic [4:0]   issue_rd_id = '0;
    logic [31:0]  issue_alt_pc = '0;
    logic         rob_full;
    logic [W-1:0] rob_next_idx;
    logic         alu_cdb_valid = 1'b0, alu_cdb_taken = 1'b0, lsb_cdb_valid = 1'b0;
    logic [W-1:0] alu_cdb_rob_idx = '0, lsb_cdb_rob_idx = '0;
    logic [31:0]  alu_cdb_val = '0, lsb_cdb_val = '0;
    logic [W-1:0] rs1_query_idx = '0, rs2_query_idx = '0;
    logic         rs1_ready, rs2_ready;
    logic [31:0]  rs1_val, rs2_val;
    logic         rob_to_rf_commit, rob_to_lsb_store_commit, clr_out;
    logic [4:0]   rob_to_rf_reg_id;
    logic [31:0]  rob_to_rf_reg_val, clr_pc;
    logic [W-1:0] rob_to_rf_rob_idx, rob_to_lsb_store_idx;

    reorder_buffer #(.ROB_WIDTH(W)) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .issue_rdy(issue_rdy), .issue_type(issue_type), .issue_rd_id(issue_rd_id),
        .issue_pred_taken(issue_pred_taken), .issue_alt_pc(issue_alt_pc),
        .rob_full(rob_full), .rob_next_idx(rob_next_idx),
        .alu_cdb_valid(alu_cdb_valid), .alu_cdb_rob_idx(alu_cdb_rob_idx),
        .alu_cdb_val(alu_cdb_val), .alu_cdb_taken(alu_cdb_taken),
        .lsb_cdb_valid(lsb_cdb_valid), .lsb_cdb_rob_idx(lsb_cdb_rob_idx),
        .lsb_cdb_val(lsb_cdb_val),
        .rs1_query_idx(rs1_query_idx), .rs2_query_idx(rs2_query_idx),
        .rs1_ready(rs1_ready), .rs2_ready(rs2_ready), .rs1_val(rs1_val), .rs2_val(rs2_val),
        .rob_to_rf_commit(rob_to_rf_commit), .rob_to_rf_reg_id(rob_to_rf_reg_id),
        .rob_to_rf_reg_val(rob_to_rf_reg_val), .rob_to_rf_rob_idx(rob_to_rf_rob_idx),
        .rob_to_lsb_store_commit(rob_to_lsb_store_commit),
        .rob_to_lsb_store_idx(rob_to_lsb_store_idx),
        .clr_out(clr_out), .clr_pc(clr_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit           rf;
        logic [4:0]   rd;
        logic [31:0]  val;
        logic [W-1:0] idx;
        bit           st;
        bit           clr;
        logic [31:0]  pc;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic         alu_v;
        logic [W-1:0] alu_idx;
        logic [31:0]  alu_val;
        logic         lsb_v;
        logic [W-1:0] lsb_idx;
        logic [31:0]  lsb_val;
        logic [W-1:0] q_idx;
        logic         exp_rdy;
        logic [31:0]  exp_val;
        bit           chk_val;
    } qvec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rf(input logic [W-1:0] idx, input logic [4:0] rd, input logic [31:0] val);
        exp_t e;
        e = '{rf: 1'b1, rd: rd, val: val, idx: idx, st: 1'b0, clr: 1'b0, pc: 32'd0};
        sb.push_back(e);
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] rd,
                         input logic pred, input logic [31:0] alt);
        issue_type = t; issue_rd_id = rd; issue_pred_taken = pred; issue_alt_pc = alt;
        issue_rdy = 1'b1;
        tick();
        issue_rdy = 1'b0;
    endtask

    task automatic alu_wb(input logic [W-1:0] idx, input logic [31:0] val, input logic tk);
        alu_cdb_valid = 1'b1; alu_cdb_rob_idx = idx; alu_cdb_val = val; alu_cdb_taken = tk;
        tick();
        alu_cdb_valid = 1'b0;
    endtask

    task automatic lsb_wb(input logic [W-1:0] idx, input logic [31:0] val);
        lsb_cdb_valid = 1'b1; lsb_cdb_rob_idx = idx; lsb_cdb_val = val;
        tick();
        lsb_cdb_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        tick();
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    // Commit monitor: each retirement pulse is counted once, in the cycle after the edge that produced it.
    logic last_ok = 1'b0;
    always @(posedge clk) last_ok <= rdy_in && rst_in;

    always @(negedge clk) begin
        if (last_ok && (rob_to_rf_commit || rob_to_lsb_store_commit || clr_out)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit rf=%0d st=%0d clr=%0d idx=%0d required=none",
                         rob_to_rf_commit, rob_to_lsb_store_commit, clr_out, rob_to_rf_rob_idx);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rf_commit", rob_to_rf_commit, e.rf);
                if (e.rf) begin
                    chk("rf_reg_id", rob_to_rf_reg_id, e.rd);
                    chk("rf_reg_val", rob_to_rf_reg_val, e.val);
                    chk("rf_rob_idx", rob_to_rf_rob_idx, e.idx);
                end
                chk("st_commit", rob_to_lsb_store_commit, e.st);
                if (e.st) chk("st_idx", rob_to_lsb_store_idx, e.idx);
                chk("clr_out", clr_out, e.clr);
                if (e.clr) chk("clr_pc", clr_pc, e.pc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        qvec_t qv[7];
        exp_t  e;

        // ---------------- Reset and out-of-order completion ----------------
        tick(); tick();
        rst_in = 1'b1;
        chk("rst_next_idx", rob_next_idx, 1);
        chk("rst_full", rob_full, 0);
        chk("rst_rf_commit", rob_to_rf_commit, 0);
        chk("rst_st_commit", rob_to_lsb_store_commit, 0);
        chk("rst_clr", clr_out, 0);
        chk("rst_clr_pc", clr_pc, 0);

        issue(2'd0, 5'd5, 1'b0, 32'd0);
        issue(2'd0, 5'd6, 1'b0, 32'd0);
        issue(2'd0, 5'd7, 1'b0, 32'd0);
        chk("issue3_next_idx", rob_next_idx, 4);
        push_rf(3'd1, 5'd5, 32'h10);
        push_rf(3'd2, 5'd6, 32'h20);
        push_rf(3'd3, 5'd7, 32'h30);
        lsb_wb(3'd3, 32'h30);
        alu_wb(3'd1, 32'h10, 1'b0);
        chk("commit1_pulse", rob_to_rf_commit, 0);
        alu_wb(3'd2, 32'h20, 1'b0);
        chk("commit1_idx", rob_to_rf_rob_idx, 1);
        tick();
        chk("commit2_idx", rob_to_rf_rob_idx, 2);
        tick();
        chk("commit3_idx", rob_to_rf_rob_idx, 3);
        wait_idle("drain_inorder");
        chk("inorder_next_idx", rob_next_idx, 4);

        // ---------------- Query table (idx4 pending, idx5 ready=0x55) ----------------
        issue(2'd0, 5'd8, 1'b0, 32'd0);
        issue(2'd0, 5'd9, 1'b0, 32'd0);
        lsb_wb(3'd5, 32'h55);
        qv[0] = '{1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 32'h0,    3'd5, 1'b1, 32'h55,   1'b1};
        qv[1] = '{1'b0, 3'd0, 32'h0,    1'b0, 3'd0, 32'h0,    3'd4, 1'b0, 32'h0,    1'b0};
        qv[2] = '{1'b1, 3'd4, 32'hABCD, 1'b0, 3'd0, 32'h0,    3'd4, 1'b1, 32'hABCD, 1'b1};
        qv[3] = '{1'b0, 3'd0, 32'h0,    1'b1, 3'd4, 32'h1234, 3'd4, 1'b1, 32'h1234, 1'b1};
        qv[4] = '{1'b1, 3'd3, 32'h77,   1'b0, 3'd0, 32'h0,    3'd0, 1'b1, 32'h0,    1'b1};
        qv[5] = '{1'b1, 3'd2, 32'hABCD, 1'b0, 3'd0, 32'h0,    3'd2, 1'b1, 32'hABCD, 1'b1};
        qv[6] = '{1'b1, 3'd5, 32'h99,   1'b0, 3'd0, 32'h0,    3'd4, 1'b0, 32'h0,    1'b0};
        for (int i = 0; i < 7; i++) begin
            alu_cdb_valid = qv[i].alu_v; alu_cdb_rob_idx = qv[i].alu_idx; alu_cdb_val = qv[i].alu_val;
            lsb_cdb_valid = qv[i].lsb_v; lsb_cdb_rob_idx = qv[i].lsb_idx; lsb_cdb_val = qv[i].lsb_val;
            rs1_query_idx = qv[i].q_idx;
            rs2_query_idx = qv[i].q_idx;
            #1;
            chk($sformatf("q%0d_rs1_ready", i), rs1_ready, qv[i].exp_rdy);
            chk($sformatf("q%0d_rs2_ready", i), rs2_ready, qv[i].exp_rdy);
            if (qv[i].chk_val) begin
                chk($sformatf("q%0d_rs1_val", i), rs1_val, qv[i].exp_val);
                chk($sformatf("q%0d_rs2_val", i), rs2_val, qv[i].exp_val);
            end
            alu_cdb_valid = 1'b0;
            lsb_cdb_valid = 1'b0;
        end
        push_rf(3'd4, 5'd8, 32'h44);
        push_rf(3'd5, 5'd9, 32'h55);
        alu_wb(3'd4, 32'h44, 1'b0);
        wait_idle("drain_query");

        // ---------------- Branch mispredict ----------------
        rst_in = 1'b0; tick(); rst_in = 1'b1;
        issue(2'd2, 5'd1, 1'b0, 32'h100);
        issue(2'd0, 5'd2, 1'b0, 32'd0);
        issue(2'd0, 5'd3, 1'b0, 32'd0);
        alu_wb(3'd2, 32'h22, 1'b0);
        alu_wb(3'd3, 32'h33, 1'b0);
        e = '{rf: 1'b1, rd: 5'd1, val: 32'h8, idx: 3'd1, st: 1'b0, clr: 1'b1, pc: 32'h100};
        sb.push_back(e);
        alu_wb(3'd1, 32'h8, 1'b1);
        // Issue during the commit cycle and during the clear cycle: both must be dropped.
        issue_type = 2'd0; issue_rd_id = 5'd4; issue_rdy = 1'b1;
        tick();
        chk("mp_clr_out", clr_out, 1);
        chk("mp_clr_pc", clr_pc, 32'h100);
        chk("mp_next_idx", rob_next_idx, 1);
        tick();
        issue_rdy = 1'b0;
        chk("mp_clr_done", clr_out, 0);
        chk("mp_issue_ignored", rob_next_idx, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("mp_no_younger", sb.size(), 0);

        // ---------------- Store commit ----------------
        issue(2'd1, 5'd0, 1'b0, 32'd0);
        e = '{rf: 1'b0, rd: 5'd0, val: 32'd0, idx: 3'd1, st: 1'b1, clr: 1'b0, pc: 32'd0};
        sb.push_back(e);
        lsb_wb(3'd1, 32'hDEAD);
        wait_idle("drain_store");

        // ---------------- rdy_in hold with a pending commit ----------------
        issue(2'd0, 5'd4, 1'b0, 32'd0);
        alu_wb(3'd2, 32'h77, 1'b0);
        rdy_in = 1'b0;
        issue_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold%0d_rf_commit", i), rob_to_rf_commit, 0);
            chk($sformatf("hold%0d_next_idx", i), rob_next_idx, 3);
            chk($sformatf("hold%0d_clr_pc", i), clr_pc, 32'h100);
        end
        issue_rdy = 1'b0;
        push_rf(3'd2, 5'd4, 32'h77);
        rdy_in = 1'b1;
        wait_idle("drain_hold");

        // ---------------- Fill to capacity and wrap past 0 ----------------
        rst_in = 1'b0; tick(); rst_in = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            issue(2'd0, 5'(i), 1'b0, 32'd0);
            if (i == 6) chk("fill6_full", rob_full, 0);
        end
        chk("fill7_full", rob_full, 1);
        chk("fill7_next_idx", rob_next_idx, 1);
        issue(2'd0, 5'd20, 1'b0, 32'd0);
        chk("fill8_full", rob_full, 1);
        chk("fill8_next_idx", rob_next_idx, 1);
        push_rf(3'd1, 5'd1, 32'h11);
        alu_wb(3'd1, 32'h11, 1'b0);
        issue_type = 2'd0; issue_rd_id = 5'd8; issue_rdy = 1'b1;
        tick();
        chk("fullcommit_full", rob_full, 0);
        chk("fullcommit_next_idx", rob_next_idx, 1);
        tick();
        issue_rdy = 1'b0;
        chk("wrap_next_idx", rob_next_idx, 2);
        chk("wrap_full", rob_full, 1);
        chk("fill_drained", sb.size(), 0);

        // ---------------- Mid-stream reset ----------------
        alu_wb(3'd2, 32'h22, 1'b0);
        rst_in = 1'b0;
        tick();
        rst_in = 1'b1;
        chk("mrst_rf_commit", rob_to_rf_commit, 0);
        chk("mrst_next_idx", rob_next_idx, 1);
        chk("mrst_full", rob_full, 0);
        chk("mrst_clr_pc", clr_pc, 0);
        chk("mrst_rf_reg_val", rob_to_rf_reg_val, 0);
        issue(2'd0, 5'd9, 1'b0, 32'd0);
        push_rf(3'd1, 5'd9, 32'h99);
        alu_wb(3'd1, 32'h99, 1'b0);
        wait_idle("drain_post_reset");
        chk("post_reset_next_idx", rob_next_idx, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
